// File: rtl/dual_issue_scheduler.sv
// Two-wide issue stage: buffers one fetched pair and issues both lanes, lane 1 only, or a load-use bubble.
// Optional statistics counters (split_cnt, bubble_cnt) are built when SCHED_STATS_EN is defined.
module dual_issue_scheduler #(
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst1,
  input  logic [INST_W-1:0] inst2,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              issue_valid1,
  output logic [INST_W-1:0] issue_inst1,
  output logic              issue_valid2,
  output logic [INST_W-1:0] issue_inst2,
  output logic              stall
`ifdef SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]  split_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {EMPTY, PAIR, SPLIT} state_t;

  // x0 is never a hazard source, so a zero register never matches.
  function automatic logic reads_reg(input logic [INST_W-1:0] i, input logic [4:0] r);
    reads_reg = 1'b0;
    if (r != 5'd0) begin
      case (i[6:0])
        OP_RTYPE, OP_STORE, OP_BRANCH: reads_reg = (i[19:15] == r) || (i[24:20] == r);
        OP_LOAD, OP_ITYPE:             reads_reg = (i[19:15] == r);
        default:                       reads_reg = 1'b0;
      endcase
    end
  endfunction

  function automatic logic writes_rd(input logic [INST_W-1:0] i);
    writes_rd = (i[6:0] == OP_LOAD) || (i[6:0] == OP_RTYPE) || (i[6:0] == OP_ITYPE);
  endfunction

  function automatic logic is_mem(input logic [INST_W-1:0] i);
    is_mem = (i[6:0] == OP_LOAD) || (i[6:0] == OP_STORE);
  endfunction

  state_t            state, state_n;
  logic [INST_W-1:0] slot1, slot2, head;
  logic [4:0]        last_ld_rd, ld_rd_n;
  logic              last_ld_v, ld_v_n;
  logic              active, load_use, split_pair, drains, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      slot1      <= '0;
      slot2      <= '0;
      last_ld_rd <= 5'd0;
      last_ld_v  <= 1'b0;
    end else begin
      state      <= state_n;
      last_ld_rd <= ld_rd_n;
      last_ld_v  <= ld_v_n;
      if (accept) begin
        slot1 <= inst1;
        slot2 <= inst2;
      end
    end
  end

  // Issue decision; outputs are held steady while ex_ready is low.
  always_comb begin
    head       = (state == SPLIT) ? slot2 : slot1;
    active     = !rst && !flush;
    load_use   = (state != EMPTY) && last_ld_v && reads_reg(head, last_ld_rd);
    split_pair = (writes_rd(slot1) && reads_reg(slot2, slot1[11:7]))
              || (writes_rd(slot1) && writes_rd(slot2) && (slot1[11:7] == slot2[11:7])
                  && (slot1[11:7] != 5'd0))
              || (is_mem(slot1) && is_mem(slot2))
              || (slot1[6:0] == OP_BRANCH);

    issue_valid1 = active && (state != EMPTY) && !load_use;
    issue_valid2 = active && (state == PAIR) && !load_use && !split_pair;
    issue_inst1  = issue_valid1 ? head : '0;
    issue_inst2  = issue_valid2 ? slot2 : '0;
    stall        = active && ex_ready && load_use;
    drains       = ex_ready && issue_valid1 && ((state == SPLIT) || issue_valid2);
    in_ready     = active && ((state == EMPTY) || drains);
    accept       = in_valid && in_ready;

    state_n = state;
    ld_v_n  = last_ld_v;
    ld_rd_n = last_ld_rd;
    if (flush) begin
      state_n = EMPTY;
      ld_v_n  = 1'b0;
    end else if (ex_ready && (state != EMPTY)) begin
      ld_v_n = 1'b0;
      if (!load_use) begin
        state_n = (state == PAIR && split_pair) ? SPLIT : EMPTY;
        if (head[6:0] == OP_LOAD) begin
          ld_v_n  = 1'b1;
          ld_rd_n = head[11:7];
        end else if (issue_valid2 && (slot2[6:0] == OP_LOAD)) begin
          ld_v_n  = 1'b1;
          ld_rd_n = slot2[11:7];
        end
      end
    end
    if (accept) state_n = PAIR;
  end

`ifdef SCHED_STATS_EN
  logic split_evt;
  assign split_evt = issue_valid1 && ex_ready && (state == PAIR) && split_pair;

  always_ff @(posedge clk) begin
    if (rst) begin
      split_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (split_evt && (split_cnt != '1)) split_cnt <= split_cnt + CNT_W'(1);
      if (stall && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_stats;
  assign unused_stats = '0;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios plus randomized traffic against a queue-based model.
module tb_dual_issue_scheduler;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst1 = '0;
  logic [31:0] inst2 = '0;
  logic        ex_ready = 1'b0;
  logic        flush = 1'b0;
  logic        issue_valid1, issue_valid2, stall;
  logic [31:0] issue_inst1, issue_inst2;
`ifdef SCHED_STATS_EN
  logic [15:0] split_cnt, bubble_cnt;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: pending instructions oldest-first plus the last issued load.
  logic [31:0] q[$];
  bit          m_ldv;
  logic [4:0]  m_ldrd;

  dual_issue_scheduler #(.INST_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst1(inst1), .inst2(inst2), .ex_ready(ex_ready), .flush(flush),
    .issue_valid1(issue_valid1), .issue_inst1(issue_inst1),
    .issue_valid2(issue_valid2), .issue_inst2(issue_inst2), .stall(stall)
`ifdef SCHED_STATS_EN
    , .split_cnt(split_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic bit m_reads(logic [31:0] i, logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (i[6:0] == RT || i[6:0] == ST || i[6:0] == BR) return (i[19:15] == r) || (i[24:20] == r);
    if (i[6:0] == LD || i[6:0] == IT) return i[19:15] == r;
    return 1'b0;
  endfunction

  function automatic bit m_writes(logic [31:0] i);
    return i[6:0] == LD || i[6:0] == RT || i[6:0] == IT;
  endfunction

  function automatic bit m_split(logic [31:0] a, logic [31:0] b);
    bit raw, waw, mem;
    raw = m_writes(a) && m_reads(b, a[11:7]);
    waw = m_writes(a) && m_writes(b) && a[11:7] == b[11:7] && a[11:7] != 5'd0;
    mem = (a[6:0] == LD || a[6:0] == ST) && (b[6:0] == LD || b[6:0] == ST);
    return raw || waw || mem || a[6:0] == BR;
  endfunction

  // Drives one cycle's inputs just after the clock edge and lets them settle.
  task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                     input logic er, input logic fl, input logic r);
    @(posedge clk);
    #1;
    in_valid = iv; inst1 = a; inst2 = b; ex_ready = er; flush = fl; rst = r;
    #1;
  endtask

  task automatic test_reset;
    cyc(1'b1, enc(RT, 1, 2, 3), enc(RT, 4, 5, 6), 1'b1, 1'b0, 1'b1);
    cyc(1'b1, enc(RT, 1, 2, 3), enc(RT, 4, 5, 6), 1'b1, 1'b0, 1'b1);
    total++;
    if ({in_ready, issue_valid1, issue_valid2, stall, issue_inst1, issue_inst2} !== 68'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got rdy=%b v1=%b v2=%b stall=%b i1=%h i2=%h want all 0",
               in_ready, issue_valid1, issue_valid2, stall, issue_inst1, issue_inst2);
    end
  endtask

  task automatic test_dual_issue;
    logic [31:0] a, b;
    a = enc(RT, 1, 2, 3); b = enc(RT, 4, 5, 6);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, a, b, 1'b1, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL dual_accept got in_ready=%b want 1", in_ready); end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, stall, issue_inst1, issue_inst2} !== {3'b110, a, b}) begin
      bad++;
      $display("[TB] FAIL dual_issue got v1=%b v2=%b stall=%b i1=%h i2=%h want 1 1 0 %h %h",
               issue_valid1, issue_valid2, stall, issue_inst1, issue_inst2, a, b);
    end
  endtask

  task automatic test_raw_split;
    logic [31:0] a, b;
    a = enc(IT, 1, 0, 5); b = enc(RT, 4, 1, 5);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, a, b, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, issue_inst1} !== {2'b10, a}) begin
      bad++; $display("[TB] FAIL raw_first got v1=%b v2=%b i1=%h want 1 0 %h", issue_valid1, issue_valid2, issue_inst1, a);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, stall, issue_inst1} !== {3'b100, b}) begin
      bad++; $display("[TB] FAIL raw_second got v1=%b v2=%b stall=%b i1=%h want 1 0 0 %h",
                      issue_valid1, issue_valid2, stall, issue_inst1, b);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, in_ready} !== 2'b01) begin
      bad++; $display("[TB] FAIL raw_drained got v1=%b rdy=%b want 0 1", issue_valid1, in_ready);
    end
  endtask

  task automatic test_load_use;
    logic [31:0] a, b, c;
    a = enc(LD, 5, 2, 0); b = enc(IT, 6, 0, 1); c = enc(RT, 7, 5, 5);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, a, b, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, c, 32'd0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, stall, in_ready} !== 4'b1101) begin
      bad++; $display("[TB] FAIL lu_first_pair got v1=%b v2=%b stall=%b rdy=%b want 1 1 0 1",
                      issue_valid1, issue_valid2, stall, in_ready);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, stall, in_ready} !== 4'b0010) begin
      bad++; $display("[TB] FAIL lu_bubble got v1=%b v2=%b stall=%b rdy=%b want 0 0 1 0",
                      issue_valid1, issue_valid2, stall, in_ready);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, stall, issue_inst1} !== {3'b110, c}) begin
      bad++; $display("[TB] FAIL lu_second_pair got v1=%b v2=%b stall=%b i1=%h want 1 1 0 %h",
                      issue_valid1, issue_valid2, stall, issue_inst1, c);
    end
  endtask

  task automatic test_mem_split;
    logic [31:0] a, b;
    a = enc(LD, 1, 2, 0); b = enc(ST, 4, 2, 3);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, a, b, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, issue_inst1} !== {2'b10, a}) begin
      bad++; $display("[TB] FAIL mem_first got v1=%b v2=%b i1=%h want 1 0 %h", issue_valid1, issue_valid2, issue_inst1, a);
    end
`ifdef SCHED_STATS_EN
    total++;
    if (split_cnt !== 16'd0) begin bad++; $display("[TB] FAIL split_cnt_before got %0d want 0", split_cnt); end
`endif
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, stall, issue_inst1} !== {3'b100, b}) begin
      bad++; $display("[TB] FAIL mem_second got v1=%b v2=%b stall=%b i1=%h want 1 0 0 %h",
                      issue_valid1, issue_valid2, stall, issue_inst1, b);
    end
`ifdef SCHED_STATS_EN
    total++;
    if (split_cnt !== 16'd1) begin bad++; $display("[TB] FAIL split_cnt_after got %0d want 1", split_cnt); end
`endif
  endtask

  task automatic test_branch_flush;
    logic [31:0] a, b;
    a = enc(BR, 0, 1, 2); b = enc(RT, 3, 3, 3);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, a, b, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, issue_inst1} !== {2'b10, a}) begin
      bad++; $display("[TB] FAIL br_issue got v1=%b v2=%b i1=%h want 1 0 %h", issue_valid1, issue_valid2, issue_inst1, a);
    end
    cyc(1'b1, enc(RT, 9, 9, 9), enc(RT, 8, 8, 8), 1'b1, 1'b1, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, in_ready} !== 3'b000) begin
      bad++; $display("[TB] FAIL br_flush got v1=%b v2=%b rdy=%b want 0 0 0", issue_valid1, issue_valid2, in_ready);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, in_ready} !== 3'b001) begin
      bad++; $display("[TB] FAIL br_after_flush got v1=%b v2=%b rdy=%b want 0 0 1", issue_valid1, issue_valid2, in_ready);
    end
  endtask

  task automatic test_reset_in_split;
    logic [31:0] a, b;
    a = enc(RT, 1, 2, 3); b = enc(RT, 4, 5, 6);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, enc(IT, 1, 0, 5), enc(RT, 4, 1, 5), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    total++;
    if ({in_ready, issue_valid1, issue_valid2, stall} !== 4'b0000) begin
      bad++; $display("[TB] FAIL split_rst_during got rdy=%b v1=%b v2=%b stall=%b want 0", in_ready, issue_valid1, issue_valid2, stall);
    end
    cyc(1'b1, a, b, 1'b1, 1'b0, 1'b0);
    total++;
    if ({in_ready, issue_valid1, issue_valid2, stall} !== 4'b1000) begin
      bad++; $display("[TB] FAIL split_rst_after got rdy=%b v1=%b v2=%b stall=%b want 1 0 0 0", in_ready, issue_valid1, issue_valid2, stall);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({issue_valid1, issue_valid2, issue_inst1, issue_inst2} !== {2'b11, a, b}) begin
      bad++; $display("[TB] FAIL split_rst_reissue got v1=%b v2=%b i1=%h i2=%h", issue_valid1, issue_valid2, issue_inst1, issue_inst2);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [6];
    int k;
    ops = '{LD, ST, RT, IT, BR, 7'h7F};
    k = $urandom_range(0, 5);
    return enc(ops[k], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
  endfunction

  task automatic test_random;
    logic        r, fl, er, iv, lu, e_v1, e_v2, e_stall, e_rdy;
    logic [31:0] a, b, e_i1, e_i2;
    int n;
    for (int cnum = 0; cnum < 600; cnum++) begin
      r  = (cnum == 0) || ($urandom_range(0, 63) == 0);
      fl = ($urandom_range(0, 15) == 0);
      er = ($urandom_range(0, 3) != 0);
      iv = ($urandom_range(0, 9) < 7);
      a  = rand_inst();
      b  = rand_inst();
      cyc(iv, a, b, er, fl, r);
      n = q.size();
      lu = (n > 0) && m_ldv && m_reads(q[0], m_ldrd);
      e_v1 = !r && !fl && n > 0 && !lu;
      e_v2 = !r && !fl && n == 2 && !lu && !m_split(q[0], q[1]);
      e_stall = !r && !fl && er && lu;
      e_i1 = e_v1 ? q[0] : 32'd0;
      e_i2 = e_v2 ? q[1] : 32'd0;
      e_rdy = !r && !fl && (n == 0 || (er && e_v1 && (n == 1 || e_v2)));
      total++;
      if ({in_ready, issue_valid1, issue_valid2, stall, issue_inst1, issue_inst2}
          !== {e_rdy, e_v1, e_v2, e_stall, e_i1, e_i2}) begin
        bad++;
        $display("[TB] FAIL random_cycle%0d got rdy=%b v1=%b v2=%b st=%b i1=%h i2=%h want rdy=%b v1=%b v2=%b st=%b i1=%h i2=%h",
                 cnum, in_ready, issue_valid1, issue_valid2, stall, issue_inst1, issue_inst2,
                 e_rdy, e_v1, e_v2, e_stall, e_i1, e_i2);
      end
      if (r || fl) begin
        q.delete();
        m_ldv = 1'b0;
      end else begin
        if (er && n > 0) begin
          m_ldv = 1'b0;
          if (!lu) begin
            if (q[0][6:0] == LD) begin m_ldv = 1'b1; m_ldrd = q[0][11:7]; end
            else if (e_v2 && q[1][6:0] == LD) begin m_ldv = 1'b1; m_ldrd = q[1][11:7]; end
            void'(q.pop_front());
            if (e_v2) void'(q.pop_front());
          end
        end
        if (iv && e_rdy) begin
          q.push_back(a);
          q.push_back(b);
        end
      end
    end
  endtask

  initial begin
    m_ldv = 1'b0;
    m_ldrd = 5'd0;
    test_reset();
    test_dual_issue();
    test_raw_split();
    test_load_use();
    test_mem_split();
    test_branch_flush();
    test_reset_in_split();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
